// File: rtl/rx_frame_store_forward.sv
// rx_frame_store_forward
// Store-and-forward receive buffer behind the MAC RX AXI4-Stream. Each frame is
// written speculatively and becomes visible to the read side only when its
// tlast beat arrives without the bad-frame flag. Bad frames and frames that do
// not fit are rewound away whole. The input side never back-pressures.
//
// Ports
//   clk156, reset              : sole clock, synchronous active-high reset
//   s_axis_*                   : RX stream from the MAC (tready tied to 1)
//   m_axis_*                   : buffered stream of complete, good frames
//   good/bad/ovf_frame_count   : saturating frame statistics
//   fifo_level                 : committed words still in RAM (not yet read)
//   wr_state                   : write FSM state (0 IDLE, 1 WRITE, 2 DISCARD)
//
// Handshake: a beat transfers on a cycle where tvalid and tready are both 1.
// Once m_axis_tvalid is raised it stays raised, with tdata/tkeep/tlast held
// stable, until the beat transfers.
module rx_frame_store_forward #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 32
) (
  input  logic              clk156,
  input  logic              reset,
  input  logic [63:0]       s_axis_tdata,
  input  logic [7:0]        s_axis_tkeep,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tuser,
  output logic              s_axis_tready,
  output logic [63:0]       m_axis_tdata,
  output logic [7:0]        m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [CNT_W-1:0]  good_frame_count,
  output logic [CNT_W-1:0]  bad_frame_count,
  output logic [CNT_W-1:0]  ovf_frame_count,
  output logic [ADDR_W:0]   fifo_level,
  output logic [1:0]        wr_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, DISCARD = 2'd2} wr_state_t;

  wr_state_t state, state_next;

  logic [72:0]   mem [DEPTH];
  logic [PW-1:0] wr_spec, wr_commit, rd_ptr;
  logic [PW-1:0] used;
  logic          space;

  logic wr_en, spec_inc, commit, rewind, good_inc, bad_inc, ovf_inc;

  // Extra pointer bit distinguishes full from empty.
  assign used  = wr_spec - rd_ptr;
  assign space = used < PW'(DEPTH);

  assign s_axis_tready = 1'b1;
  assign wr_state      = state;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk156) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (s_axis_tvalid) begin
      case (state)
        IDLE, WRITE: begin
          if (space) state_next = s_axis_tlast ? IDLE : WRITE;
          else       state_next = s_axis_tlast ? IDLE : DISCARD;
        end
        DISCARD: if (s_axis_tlast) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    spec_inc = 1'b0;
    commit   = 1'b0;
    rewind   = 1'b0;
    good_inc = 1'b0;
    bad_inc  = 1'b0;
    ovf_inc  = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        IDLE, WRITE: begin
          if (space) begin
            wr_en = 1'b1;
            if (s_axis_tlast && s_axis_tuser) begin
              // Bad frame: the word just written is abandoned by the rewind.
              rewind  = 1'b1;
              bad_inc = 1'b1;
            end else begin
              spec_inc = 1'b1;
              if (s_axis_tlast) begin
                commit   = 1'b1;
                good_inc = 1'b1;
              end
            end
          end else begin
            rewind = 1'b1;
            if (s_axis_tlast) ovf_inc = 1'b1;
          end
        end
        DISCARD: if (s_axis_tlast) ovf_inc = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------- write pointers and RAM ----------------
  always_ff @(posedge clk156) begin
    if (reset) begin
      wr_spec   <= '0;
      wr_commit <= '0;
    end else begin
      if (rewind)        wr_spec <= wr_commit;
      else if (spec_inc) wr_spec <= wr_spec + 1'b1;
      if (commit)        wr_commit <= wr_spec + 1'b1;
    end
  end

  always_ff @(posedge clk156) begin
    if (wr_en) mem[wr_spec[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  // ---------------- read path ----------------
  logic [72:0] ram_q, skid0, skid1, head;
  logic [1:0]  skid_cnt, occ;
  logic        rd_valid, rd_en, pop;

  // Occupancy counts the RAM read in flight so the skid can never overrun.
  assign occ   = skid_cnt + 2'(rd_valid);
  assign rd_en = (rd_ptr != wr_commit) && (occ < 2'd2);
  assign pop   = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk156) begin
    if (rd_en) ram_q <= mem[rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk156) begin
    if (reset) begin
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Queue order is skid0, skid1, then the fresh RAM word; the RAM word is
  // shown directly when the skid is empty so a frame leaves two cycles after
  // its commit.
  always_ff @(posedge clk156) begin
    if (reset) begin
      skid0    <= '0;
      skid1    <= '0;
      skid_cnt <= 2'd0;
    end else begin
      case (skid_cnt)
        2'd0: begin
          if (rd_valid && !pop) begin
            skid0    <= ram_q;
            skid_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (pop) begin
            if (rd_valid) skid0 <= ram_q;
            else          skid_cnt <= 2'd0;
          end else if (rd_valid) begin
            skid1    <= ram_q;
            skid_cnt <= 2'd2;
          end
        end
        default: begin
          if (pop) begin
            skid0    <= skid1;
            skid_cnt <= 2'd1;
          end
        end
      endcase
    end
  end

  assign head          = (skid_cnt == 2'd0 && rd_valid) ? ram_q : skid0;
  assign m_axis_tvalid = (skid_cnt != 2'd0) || rd_valid;
  assign m_axis_tlast  = head[72];
  assign m_axis_tkeep  = head[71:64];
  assign m_axis_tdata  = head[63:0];
  assign fifo_level    = wr_commit - rd_ptr;

  // ---------------- statistics ----------------
  always_ff @(posedge clk156) begin
    if (reset) begin
      good_frame_count <= '0;
      bad_frame_count  <= '0;
      ovf_frame_count  <= '0;
    end else begin
      if (good_inc && good_frame_count != '1) good_frame_count <= good_frame_count + 1'b1;
      if (bad_inc  && bad_frame_count  != '1) bad_frame_count  <= bad_frame_count  + 1'b1;
      if (ovf_inc  && ovf_frame_count  != '1) ovf_frame_count  <= ovf_frame_count  + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_store_forward.sv
// Bench for rx_frame_store_forward, built with a 16-word buffer so overflow
// and pointer wrap are reachable quickly.
module tb_rx_frame_store_forward;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 32;

  // ---------------- clock / reset ----------------
  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;
  logic reset;

  logic [63:0]      s_tdata;
  logic [7:0]       s_tkeep;
  logic             s_tvalid, s_tlast, s_tuser, s_tready;
  logic [63:0]      m_tdata;
  logic [7:0]       m_tkeep;
  logic             m_tvalid, m_tlast, m_tready;
  logic [CNT_W-1:0] good_cnt, bad_cnt, ovf_cnt;
  logic [ADDR_W:0]  fifo_level;
  logic [1:0]       wr_state;

  rx_frame_store_forward #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk156(clk156), .reset(reset),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .good_frame_count(good_cnt), .bad_frame_count(bad_cnt), .ovf_frame_count(ovf_cnt),
    .fifo_level(fifo_level), .wr_state(wr_state)
  );

  // kind: 0 good (delivered), 1 bad (tuser), 2 overflow
  typedef struct {
    int         len;
    bit         user;
    logic [7:0] keep;
    int         kind;
  } frame_t;

  int          checks = 0;
  int          errors = 0;
  logic [72:0] exp_q[$];
  int          exp_good = 0, exp_bad = 0, exp_ovf = 0;
  int          fid = 0;
  int          max_level = 0;
  bit          prev_hold = 1'b0;
  logic [72:0] prev_word, got_word, exp_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    @(posedge clk156);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_frame(input int len, input bit user, input logic [7:0] keep, input int kind);
    logic [63:0] d;
    logic [7:0]  k;
    bit          l;
    fid++;
    for (int b = 0; b < len; b++) begin
      d = {fid, b};
      l = (b == len - 1);
      k = l ? keep : 8'hFF;
      if (kind == 0) exp_q.push_back({l, k, d});
      send_beat(d, k, l, l ? user : 1'b0);
    end
    case (kind)
      0: exp_good++;
      1: exp_bad++;
      default: exp_ovf++;
    endcase
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && fifo_level == 0 && !m_tvalid) && n < 500) begin
      @(posedge clk156);
      #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d beats still expected", name, exp_q.size());
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_good"}, 64'(good_cnt), 64'(exp_good));
    check({tag, "_bad"},  64'(bad_cnt),  64'(exp_bad));
    check({tag, "_ovf"},  64'(ovf_cnt),  64'(exp_ovf));
    check({tag, "_level"}, 64'(fifo_level), 64'd0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk156) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      got_word = {m_tlast, m_tkeep, m_tdata};
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (prev_hold) begin
        checks++;
        if (!m_tvalid || got_word !== prev_word) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b %0h expected v=1 %0h", m_tvalid, got_word, prev_word);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", got_word);
        end else begin
          exp_word = exp_q.pop_front();
          if (got_word !== exp_word) begin
            errors++;
            $display("FAIL out_beat: got %0h expected %0h", got_word, exp_word);
          end
        end
      end
      prev_hold = m_tvalid && !m_tready;
      prev_word = got_word;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  frame_t tbl[9];

  initial begin
    tbl[0] = '{8,  1'b0, 8'h0F, 0};  // latency checked on this one
    tbl[1] = '{5,  1'b1, 8'hFF, 1};
    tbl[2] = '{3,  1'b0, 8'hFF, 0};
    tbl[3] = '{1,  1'b0, 8'h01, 0};
    tbl[4] = '{1,  1'b1, 8'hFF, 1};
    tbl[5] = '{20, 1'b0, 8'hFF, 2};  // overflow, ends in DISCARD
    tbl[6] = '{16, 1'b0, 8'h3F, 0};  // exactly fills the buffer
    tbl[7] = '{17, 1'b0, 8'hFF, 2};  // tlast is the beat that finds no space
    tbl[8] = '{2,  1'b0, 8'hFF, 0};

    reset    = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk156);
    #1;
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tdata",  m_tdata, 64'd0);
    check("rst_tready", 64'(s_tready), 64'd1);
    check("rst_state",  64'(wr_state), 64'd0);
    check_counts("rst");
    reset = 1'b0;

    // Table of frames, each into an empty buffer with the sink always ready.
    for (int i = 0; i < 9; i++) begin
      drain($sformatf("tbl%0d_pre", i));
      send_frame(tbl[i].len, tbl[i].user, tbl[i].keep, tbl[i].kind);
      if (i == 0) begin
        check("lat_n1_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge clk156);
        #1;
        check("lat_n2_tvalid", 64'(m_tvalid), 64'd1);
      end
      drain($sformatf("tbl%0d", i));
      check_counts($sformatf("tbl%0d", i));
    end

    // Overflow with the sink stalled: second frame cannot fit.
    m_tready = 1'b0;
    send_frame(10, 1'b0, 8'hFF, 0);
    send_frame(10, 1'b0, 8'hFF, 2);
    repeat (5) @(posedge clk156);
    #1;
    check("ovf_hold_tvalid", 64'(m_tvalid), 64'd1);
    check("ovf_hold_level", 64'(fifo_level), 64'd8);  // two words parked in the skid
    check("ovf_cnt_stalled", 64'(ovf_cnt), 64'(exp_ovf));
    m_tready = 1'b1;
    drain("ovf_release");
    check_counts("ovf1");
    send_frame(20, 1'b0, 8'hFF, 2);
    drain("ovf_long");
    check_counts("ovf2");

    // Back-pressure: three back-to-back frames with the sink toggling.
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(4, 1'b0, 8'hFF, 0);
      end
      begin
        for (int c = 0; c < 40; c++) begin
          @(posedge clk156);
          #1;
          m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
    join
    drain("bp");
    check_counts("bp");

    // Pointer wrap: forty single-beat frames back to back.
    max_level = 0;
    for (int f = 0; f < 40; f++) send_frame(1, 1'b0, 8'($urandom_range(1, 255)), 0);
    drain("wrap");
    check_counts("wrap");
    checks++;
    if (max_level > 16) begin
      errors++;
      $display("FAIL wrap_max_level: got %0d expected at most 16", max_level);
    end

    // Reset in the middle of a frame: the partial frame disappears.
    fid++;
    send_beat({fid, 32'd0}, 8'hFF, 1'b0, 1'b0);
    send_beat({fid, 32'd1}, 8'hFF, 1'b0, 1'b0);
    reset    = 1'b1;
    s_tdata  = {fid, 32'd2};
    s_tkeep  = 8'hFF;
    s_tvalid = 1'b1;
    @(posedge clk156);
    #1;
    reset    = 1'b0;
    s_tvalid = 1'b0;
    exp_good = 0;
    exp_bad  = 0;
    exp_ovf  = 0;
    check("midrst_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_state", 64'(wr_state), 64'd0);
    check_counts("midrst");
    send_frame(2, 1'b0, 8'h07, 0);
    drain("post_rst");
    check_counts("post_rst");

    repeat (3) @(posedge clk156);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected: got %0d beats pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
